fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register, directly upstream of the load-use stall unit.
//  - Drives PC to instruction memory and latches the fetched 16-bit instruction and PC+1 into IF/ID.
//  - Consumes the stall pulse: holds PC and IF/ID for that cycle.
//  - Handles EX-stage redirects (branch/jal/jr) by flushing IF/ID, and freezes fetch when hlt is fetched.
// PARAMETERS
//  ADDR_W     16        PC / imem address width (word addressed)
//  RESET_PC   16'h0000  PC value after reset
//  NOP_INSTR  16'h0000  bubble encoding (add r0,r0,r0)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       synchronous, active-high reset
//  stall           in   1       hold request from stall unit (single-cycle pulse)
//  redirect_valid  in   1       EX resolved taken branch / jal / jr
//  redirect_pc     in   ADDR_W  target PC for redirect
//  halt_commit     in   1       hlt has retired in WB
//  imem_rd_data    in   16      instruction at imem_addr (combinational read)
//  imem_addr       out  ADDR_W  = PC (combinational)
//  imem_rd_en      out  1       = !stall && state!=HALTED && state!=HALT_WAIT
//  id_instr        out  16      IF/ID instruction register
//  id_pc_plus1     out  ADDR_W  IF/ID PC+1 register
//  id_valid        out  1       IF/ID holds a real instruction
//  halted          out  1       high in HALTED state
// BEHAVIOUR
//  Reset (rst=1 at posedge): PC=RESET_PC, id_instr=NOP_INSTR, id_pc_plus1=0, id_valid=0, state=RUN, halted=0.
//  Per-edge priority: rst > halt_commit > redirect_valid > stall > normal.
//  FSM states RUN, HALT_WAIT, HALTED:
//   RUN, normal: PC<=PC+1; IF/ID<={imem_rd_data, PC+1, 1}.
//    If imem_rd_data[15:12]==4'hF (hlt), also go to HALT_WAIT and leave PC unchanged (hlt address).
//   RUN, stall: PC, id_instr, id_pc_plus1, id_valid all hold. Latency of hold is exactly one edge per stall cycle.
//   HALT_WAIT: PC frozen; IF/ID<=NOP bubble (id_valid=0) every edge after hlt is latched; stall ignored.
//   Any state except HALTED, redirect_valid: PC<=redirect_pc; IF/ID<=NOP bubble, id_valid=0; state<=RUN.
//    Redirect wins over a simultaneous stall and cancels a wrong-path HALT_WAIT.
//   halt_commit (from RUN or HALT_WAIT): state<=HALTED; IF/ID<=bubble.
//   HALTED: terminal until rst; PC and IF/ID frozen at bubble; redirect ignored; halted=1.
//  Arithmetic: PC+1 is ADDR_W wide, wraps 0xFFFF->0x0000 with no flag.
//  Redirect to the address currently in PC is legal and still flushes.
//  rst asserted mid-stall or mid-halt: full reset values next edge; no state survives.
//  No combinational path from stall/redirect_valid to id_* outputs (registers only).
// STRUCTURE
//  Shared package: opcode constants (addOp..jrOp, hltOp=4'hF), NOP_INSTR, FSM state encoding (2-bit, RUN=00).
//  Sub-module pc_register: PC flop with load (redirect), hold (stall/halt), increment; fetch_stage owns IF/ID and FSM.
// TESTING
//  Reset, imem returns 0x0001,0x0002,... -> imem_addr 0,1,2; id_instr lags one edge; id_valid=1 from 2nd edge.
//  stall=1 one cycle at PC=5 -> PC stays 5, id_instr unchanged that edge; PC=6 next edge.
//  stall=1 and redirect_valid=1, redirect_pc=0x0040 same cycle -> PC=0x0040, id_valid=0, id_instr=0x0000.
//  Fetch 0xF000 at PC=9 -> state HALT_WAIT, PC held 9, bubbles follow; redirect_pc=0x0020 -> RUN, PC=0x0020.
//  hlt fetched, then halt_commit=1 -> halted=1, imem_rd_en=0; later redirect_valid ignored; rst -> PC=0, halted=0.
//  PC=0xFFFF, no stall -> next PC=0x0000, id_pc_plus1=0x0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcode constants, bubble encoding and fetch FSM state encoding.
package fetch_stage_pkg;
  localparam logic [3:0] addOp = 4'h0;
  localparam logic [3:0] subOp = 4'h1;
  localparam logic [3:0] andOp = 4'h2;
  localparam logic [3:0] orOp  = 4'h3;
  localparam logic [3:0] lwOp  = 4'h4;
  localparam logic [3:0] swOp  = 4'h5;
  localparam logic [3:0] beqOp = 4'h6;
  localparam logic [3:0] jalOp = 4'h7;
  localparam logic [3:0] jrOp  = 4'h8;
  localparam logic [3:0] hltOp = 4'hF;
  localparam logic [15:0] NOP_ENC = 16'h0000;
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HALT_WAIT = 2'b01,
    HALTED    = 2'b10
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_register.sv
// fetch_stage_pc_register: PC flop with load, increment and hold.
module fetch_stage_pc_register #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);
  logic [ADDR_W-1:0] r_pc;
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_pc;
    else if (i_inc) r_pc <= r_pc + 1'b1;
  end
  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with IF/ID register, stall hold, redirect flush and hlt freeze FSM.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_commit,
  input  logic [15:0]       imem_rd_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  output logic [15:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_plus1,
  output logic              id_valid,
  output logic              halted
);
  fetch_state_t      r_state;
  logic [15:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_plus1;
  logic              r_valid;
  logic              r_halted;
  logic [ADDR_W-1:0] w_pc;
  logic              w_live;
  logic              w_commit;
  logic              w_redirect;
  logic              w_hlt;
  logic              w_advance;
  assign w_live     = r_state != HALTED;
  assign w_commit   = halt_commit && w_live;
  assign w_redirect = redirect_valid && w_live && !halt_commit;
  assign w_hlt      = imem_rd_data[15:12] == hltOp;
  assign w_advance  = r_state == RUN && !halt_commit && !redirect_valid && !stall;
  fetch_stage_pc_register #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_redirect),
    .i_load_pc (redirect_pc),
    .i_inc     (w_advance && !w_hlt),
    .o_pc      (w_pc)
  );
  // A fetched hlt stays in IF/ID as a real instruction; PC parks on its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_instr    <= NOP_INSTR;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else if (w_commit || w_redirect || r_state == HALT_WAIT) begin
      r_state    <= w_commit ? HALTED : w_redirect ? RUN : HALT_WAIT;
      r_halted   <= w_commit;
      r_instr    <= NOP_INSTR;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
    end else if (w_advance) begin
      r_state    <= w_hlt ? HALT_WAIT : RUN;
      r_instr    <= imem_rd_data;
      r_pc_plus1 <= w_pc + 1'b1;
      r_valid    <= 1'b1;
    end
  end
  assign imem_addr   = w_pc;
  assign imem_rd_en  = !stall && r_state == RUN;
  assign id_instr    = r_instr;
  assign id_pc_plus1 = r_pc_plus1;
  assign id_valid    = r_valid;
  assign halted      = r_halted;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests for fetch_stage with a behavioural imem returning addr+1 (or hlt at one address).
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_commit = 1'b0;
  logic [15:0] imem_rd_data;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus1;
  logic        id_valid;
  logic        halted;
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_addr = '0;
  int          pass = 0;
  int          total = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_commit    (halt_commit),
    .imem_rd_data   (imem_rd_data),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .id_instr       (id_instr),
    .id_pc_plus1    (id_pc_plus1),
    .id_valid       (id_valid),
    .halted         (halted)
  );

  always #5 clk = ~clk;
  assign imem_rd_data = (hlt_en && imem_addr == hlt_addr) ? 16'hF000 : imem_addr + 16'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (imem_addr !== 16'h0000) $display("FAIL reset_pc got %h exp 0000", imem_addr); else pass++;
    total++; if (id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", id_valid); else pass++;
    total++; if (id_instr !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", id_instr); else pass++;
    total++; if (id_pc_plus1 !== 16'h0000) $display("FAIL reset_pc1 got %h exp 0000", id_pc_plus1); else pass++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else pass++;
    total++; if (imem_rd_en !== 1'b1) $display("FAIL reset_rd_en got %b exp 1", imem_rd_en); else pass++;
  endtask

  task automatic test_fetch();
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (imem_addr !== 16'(i)) $display("FAIL fetch_pc%0d got %h exp %h", i, imem_addr, 16'(i)); else pass++;
      total++; if (id_instr !== 16'(i)) $display("FAIL fetch_instr%0d got %h exp %h", i, id_instr, 16'(i)); else pass++;
      total++; if (id_pc_plus1 !== 16'(i)) $display("FAIL fetch_pc1_%0d got %h exp %h", i, id_pc_plus1, 16'(i)); else pass++;
      total++; if (id_valid !== 1'b1) $display("FAIL fetch_valid%0d got %b exp 1", i, id_valid); else pass++;
    end
  endtask

  task automatic test_stall();
    jump(16'h0004);
    tick();
    total++; if (imem_addr !== 16'h0005) $display("FAIL stall_pre_pc got %h exp 0005", imem_addr); else pass++;
    stall = 1'b1;
    #1;
    total++; if (imem_rd_en !== 1'b0) $display("FAIL stall_rd_en got %b exp 0", imem_rd_en); else pass++;
    tick();
    stall = 1'b0;
    total++; if (imem_addr !== 16'h0005) $display("FAIL stall_pc got %h exp 0005", imem_addr); else pass++;
    total++; if (id_instr !== 16'h0005) $display("FAIL stall_instr got %h exp 0005", id_instr); else pass++;
    total++; if (id_valid !== 1'b1) $display("FAIL stall_valid got %b exp 1", id_valid); else pass++;
    tick();
    total++; if (imem_addr !== 16'h0006) $display("FAIL stall_post_pc got %h exp 0006", imem_addr); else pass++;
    total++; if (id_instr !== 16'h0006) $display("FAIL stall_post_instr got %h exp 0006", id_instr); else pass++;
    total++; if (id_pc_plus1 !== 16'h0006) $display("FAIL stall_post_pc1 got %h exp 0006", id_pc_plus1); else pass++;
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    jump(16'h0040);
    stall = 1'b0;
    total++; if (imem_addr !== 16'h0040) $display("FAIL sr_pc got %h exp 0040", imem_addr); else pass++;
    total++; if (id_valid !== 1'b0) $display("FAIL sr_valid got %b exp 0", id_valid); else pass++;
    total++; if (id_instr !== 16'h0000) $display("FAIL sr_instr got %h exp 0000", id_instr); else pass++;
    jump(16'h0040);
    total++; if (imem_addr !== 16'h0040) $display("FAIL self_redirect_pc got %h exp 0040", imem_addr); else pass++;
    total++; if (id_valid !== 1'b0) $display("FAIL self_redirect_valid got %b exp 0", id_valid); else pass++;
  endtask

  task automatic test_halt_wait();
    hlt_en = 1'b1;
    hlt_addr = 16'h0009;
    jump(16'h0008);
    tick();
    total++; if (imem_addr !== 16'h0009) $display("FAIL hw_pre_pc got %h exp 0009", imem_addr); else pass++;
    tick();
    total++; if (imem_addr !== 16'h0009) $display("FAIL hw_pc got %h exp 0009", imem_addr); else pass++;
    total++; if (id_instr !== 16'hF000) $display("FAIL hw_instr got %h exp f000", id_instr); else pass++;
    total++; if (id_valid !== 1'b1) $display("FAIL hw_valid got %b exp 1", id_valid); else pass++;
    total++; if (imem_rd_en !== 1'b0) $display("FAIL hw_rd_en got %b exp 0", imem_rd_en); else pass++;
    stall = 1'b1;
    tick();
    stall = 1'b0;
    total++; if (imem_addr !== 16'h0009) $display("FAIL hw_bubble_pc got %h exp 0009", imem_addr); else pass++;
    total++; if (id_valid !== 1'b0) $display("FAIL hw_bubble_valid got %b exp 0", id_valid); else pass++;
    total++; if (id_instr !== 16'h0000) $display("FAIL hw_bubble_instr got %h exp 0000", id_instr); else pass++;
    jump(16'h0020);
    total++; if (imem_addr !== 16'h0020) $display("FAIL hw_redirect_pc got %h exp 0020", imem_addr); else pass++;
    total++; if (imem_rd_en !== 1'b1) $display("FAIL hw_redirect_rd_en got %b exp 1", imem_rd_en); else pass++;
    tick();
    total++; if (imem_addr !== 16'h0021) $display("FAIL hw_resume_pc got %h exp 0021", imem_addr); else pass++;
    total++; if (id_instr !== 16'h0021) $display("FAIL hw_resume_instr got %h exp 0021", id_instr); else pass++;
  endtask

  task automatic test_halt_commit();
    jump(16'h0009);
    tick();
    halt_commit = 1'b1;
    tick();
    halt_commit = 1'b0;
    total++; if (halted !== 1'b1) $display("FAIL hc_halted got %b exp 1", halted); else pass++;
    total++; if (imem_rd_en !== 1'b0) $display("FAIL hc_rd_en got %b exp 0", imem_rd_en); else pass++;
    total++; if (id_valid !== 1'b0) $display("FAIL hc_valid got %b exp 0", id_valid); else pass++;
    jump(16'h0030);
    total++; if (imem_addr !== 16'h0009) $display("FAIL hc_redirect_pc got %h exp 0009", imem_addr); else pass++;
    total++; if (halted !== 1'b1) $display("FAIL hc_redirect_halted got %b exp 1", halted); else pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hlt_en = 1'b0;
    total++; if (imem_addr !== 16'h0000) $display("FAIL hc_rst_pc got %h exp 0000", imem_addr); else pass++;
    total++; if (halted !== 1'b0) $display("FAIL hc_rst_halted got %b exp 0", halted); else pass++;
    total++; if (imem_rd_en !== 1'b1) $display("FAIL hc_rst_rd_en got %b exp 1", imem_rd_en); else pass++;
  endtask

  task automatic test_wrap();
    jump(16'hFFFF);
    tick();
    total++; if (imem_addr !== 16'h0000) $display("FAIL wrap_pc got %h exp 0000", imem_addr); else pass++;
    total++; if (id_pc_plus1 !== 16'h0000) $display("FAIL wrap_pc1 got %h exp 0000", id_pc_plus1); else pass++;
    total++; if (id_valid !== 1'b1) $display("FAIL wrap_valid got %b exp 1", id_valid); else pass++;
  endtask

  task automatic test_reset_mid_stall();
    tick();
    tick();
    stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    total++; if (imem_addr !== 16'h0000) $display("FAIL rst_stall_pc got %h exp 0000", imem_addr); else pass++;
    total++; if (id_valid !== 1'b0) $display("FAIL rst_stall_valid got %b exp 0", id_valid); else pass++;
    total++; if (id_instr !== 16'h0000) $display("FAIL rst_stall_instr got %h exp 0000", id_instr); else pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stall();
    test_stall_redirect();
    test_halt_wait();
    test_halt_commit();
    test_wrap();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
